// File: rtl/unary_emit.sv
// unary_emit: turns a count word into a WIN-bit serial stream carrying min(in_cnt,WIN) ones.
// Define UNARY_SPREAD_EN to spread the ones evenly (Bresenham) instead of sending them first.
module unary_emit #(
  parameter int DW  = 8,
  parameter int WIN = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_cnt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last
);
  localparam int IW = $clog2(WIN + 1);
  localparam logic [DW-1:0] WIN_CNT  = DW'(WIN);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIN - 1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t        state_q;
  logic [DW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] cnt_d;
  logic          emit_act;
  logic          accept;
  logic          handshake;
  logic          at_last;
  logic          bit_d;

  assign emit_act  = (state_q == EMIT);
  assign in_ready  = ~emit_act & en & ~clr;
  assign out_valid = emit_act & en;
  assign at_last   = (idx_q == LAST_IDX);
  assign out_last  = emit_act & at_last;
  assign out_bit   = emit_act & bit_d;
  assign accept    = in_valid & in_ready;
  // clr wins over a handshake offered in the same cycle
  assign handshake = out_valid & out_ready & ~clr;
  assign cnt_d     = (in_cnt > WIN_CNT) ? WIN_CNT : in_cnt;

`ifdef UNARY_SPREAD_EN
  localparam logic [DW:0] WIN_ERR = (DW + 1)'(WIN);
  logic [DW:0] err_q;
  logic [DW:0] sum_d;

  assign sum_d = err_q + {1'b0, cnt_q};
  assign bit_d = (sum_d >= WIN_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (accept) begin
      err_q <= '0;
    end else if (handshake) begin
      err_q <= bit_d ? (sum_d - WIN_ERR) : sum_d;
    end
  end
`else
  assign bit_d = ({{DW{1'b0}}, idx_q} < {{IW{1'b0}}, cnt_q});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (clr) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else if (accept) begin
      cnt_q   <= cnt_d;
      idx_q   <= '0;
      state_q <= EMIT;
    end else if (handshake) begin
      if (at_last) begin
        state_q <= IDLE;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

endmodule
